colorram_arbiter: RTL and testbench

- Time-shares the 2k×16 colour RAM between CPU bus accesses and the video palette lookup. The RAM is two 2k×8 chips (high byte, low byte), each with a synchronous 1-cycle read.
- Video fetch owns every pixel slot; CPU reads and writes use the remaining MCLK cycles.
- Returns CPU data with a DTACK handshake and drives registered 15-bit RGB to the video output stage.

---
 rtl/colorram_pkg.sv | 17 +
 rtl/colorram_cpu_port.sv | 148 ++++++++++++++
 rtl/colorram_arbiter.sv | 119 +++++++++++
 tb/tb_colorram_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/colorram_pkg.sv
// Shared types and constants for the colour RAM arbiter.
// Optional build macro: COLORRAM_CONTENTION_EN (see colorram_cpu_port).
package colorram_pkg;

  localparam int unsigned COLORRAM_ADDR_W = 11;
  localparam int unsigned COLORRAM_RGB_W  = 15;

  // CPU access sequencing: request latched, RAM cycle issued,
  // read data captured, then DTACK held until the CPU drops CS_n.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } cpu_state_e;

endpackage

// File: rtl/colorram_cpu_port.sv
// CPU side of the colour RAM: request latches, access FSM, DTACK and read data.
// Build macro COLORRAM_CONTENTION_EN: when defined, the RAM cycle is also held
// off while video is active (VID_BLANK = 0), as on the original board.
module colorram_cpu_port
  import colorram_pkg::*;
#(
  parameter int unsigned ADDR_W = COLORRAM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pxcen_i,
  input  logic              vid_blank_i,
  input  logic              cs_ni,
  input  logic              r_nw_i,
  input  logic              uds_ni,
  input  logic              lds_ni,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       din_i,
  input  logic [15:0]       ram_dout_i,
  output logic [15:0]       dout_o,
  output logic              dtack_no,
  output logic              issue_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [15:0]       req_din_o,
  output logic              req_rd_no,
  output logic              req_wr_hi_no,
  output logic              req_wr_lo_no
);

`ifdef COLORRAM_CONTENTION_EN
  localparam logic CONTENTION = 1'b1;
`else
  localparam logic CONTENTION = 1'b0;
`endif

  cpu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic              rnw_q, rnw_d;
  logic              uds_n_q, uds_n_d;
  logic              lds_n_q, lds_n_d;
  logic              abort_q, abort_d;
  logic [15:0]       dout_q, dout_d;
  logic              dtack_n_q, dtack_n_d;
  logic              stall_s;

  // A video slot always owns the RAM; with contention, active display does too.
  assign stall_s = pxcen_i | (CONTENTION & ~vid_blank_i);

  // Next-state logic for the access sequencer and its request latches.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rnw_d   = rnw_q;
    uds_n_d = uds_n_q;
    lds_n_d = lds_n_q;
    abort_d = abort_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (!cs_ni) begin
          addr_d  = addr_i;
          din_d   = din_i;
          rnw_d   = r_nw_i;
          uds_n_d = uds_ni;
          lds_n_d = lds_ni;
          abort_d = 1'b0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // A CPU that gives up mid-access still gets a clean RAM cycle, just no DTACK.
        if (cs_ni) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        if (!stall_s) begin
          state_d = CAPTURE;
        end else begin
          state_d = ISSUE;
        end
      end
      CAPTURE: begin
        // RAM output here is still the CPU's word even if a video slot is in progress.
        if (rnw_q) begin
          dout_d = ram_dout_i;
        end else begin
          dout_d = dout_q;
        end
        if (cs_ni || abort_q) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (cs_ni) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    dtack_n_d = (state_d != ACK);
  end

  // State, request latches and CPU-visible outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      din_q     <= 16'h0000;
      rnw_q     <= 1'b1;
      uds_n_q   <= 1'b1;
      lds_n_q   <= 1'b1;
      abort_q   <= 1'b0;
      dout_q    <= 16'h0000;
      dtack_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rnw_q     <= rnw_d;
      uds_n_q   <= uds_n_d;
      lds_n_q   <= lds_n_d;
      abort_q   <= abort_d;
      dout_q    <= dout_d;
      dtack_n_q <= dtack_n_d;
    end
  end

  assign issue_o      = (state_q == ISSUE) && !stall_s;
  assign req_addr_o   = addr_q;
  assign req_din_o    = din_q;
  assign req_rd_no    = ~rnw_q;
  assign req_wr_hi_no = rnw_q | uds_n_q;
  assign req_wr_lo_no = rnw_q | lds_n_q;
  assign dout_o       = dout_q;
  assign dtack_no     = dtack_n_q;

endmodule

// File: rtl/colorram_arbiter.sv
// Colour RAM arbiter: shares the 2k x 16 palette RAM between video lookup
// (every pixel slot) and CPU accesses (remaining cycles).
// Build macro COLORRAM_CONTENTION_EN restricts CPU accesses to blanking.
module colorram_arbiter
  import colorram_pkg::*;
#(
  parameter int unsigned ADDR_W = COLORRAM_ADDR_W,
  parameter int unsigned RGB_W  = COLORRAM_RGB_W
) (
  input  logic              i_MCLK,
  input  logic              i_RST_n,
  input  logic              i_PXCEN,
  input  logic [ADDR_W-1:0] i_VID_ADDR,
  input  logic              i_VID_BLANK,
  input  logic              i_CPU_CS_n,
  input  logic              i_CPU_R_nW,
  input  logic              i_CPU_UDS_n,
  input  logic              i_CPU_LDS_n,
  input  logic [ADDR_W-1:0] i_CPU_ADDR,
  input  logic [15:0]       i_CPU_DIN,
  output logic [15:0]       o_CPU_DOUT,
  output logic              o_CPU_DTACK_n,
  output logic [ADDR_W-1:0] o_RAM_ADDR,
  output logic [15:0]       o_RAM_DIN,
  output logic              o_RAM_WR_HI_n,
  output logic              o_RAM_WR_LO_n,
  output logic              o_RAM_RD_n,
  input  logic [15:0]       i_RAM_DOUT,
  output logic [RGB_W-1:0]  o_RGB,
  output logic              o_RGB_VALID
);

  logic              cpu_issue_s;
  logic [ADDR_W-1:0] cpu_addr_s;
  logic [15:0]       cpu_din_s;
  logic              cpu_rd_n_s;
  logic              cpu_wr_hi_n_s;
  logic              cpu_wr_lo_n_s;

  logic              vid_pend_q;
  logic              vid_blank_q;
  logic [RGB_W-1:0]  rgb_q;
  logic              rgb_valid_q;

  colorram_cpu_port #(
    .ADDR_W (ADDR_W)
  ) u_cpu_port (
    .clk_i        (i_MCLK),
    .rst_ni       (i_RST_n),
    .pxcen_i      (i_PXCEN),
    .vid_blank_i  (i_VID_BLANK),
    .cs_ni        (i_CPU_CS_n),
    .r_nw_i       (i_CPU_R_nW),
    .uds_ni       (i_CPU_UDS_n),
    .lds_ni       (i_CPU_LDS_n),
    .addr_i       (i_CPU_ADDR),
    .din_i        (i_CPU_DIN),
    .ram_dout_i   (i_RAM_DOUT),
    .dout_o       (o_CPU_DOUT),
    .dtack_no     (o_CPU_DTACK_n),
    .issue_o      (cpu_issue_s),
    .req_addr_o   (cpu_addr_s),
    .req_din_o    (cpu_din_s),
    .req_rd_no    (cpu_rd_n_s),
    .req_wr_hi_no (cpu_wr_hi_n_s),
    .req_wr_lo_no (cpu_wr_lo_n_s)
  );

  // RAM port mux: reset silences the RAM, then video, then CPU, else idle.
  always_comb begin
    o_RAM_ADDR    = i_VID_ADDR;
    o_RAM_DIN     = cpu_din_s;
    o_RAM_RD_n    = 1'b1;
    o_RAM_WR_HI_n = 1'b1;
    o_RAM_WR_LO_n = 1'b1;
    if (!i_RST_n) begin
      o_RAM_RD_n    = 1'b1;
      o_RAM_WR_HI_n = 1'b1;
      o_RAM_WR_LO_n = 1'b1;
    end else if (i_PXCEN) begin
      o_RAM_ADDR = i_VID_ADDR;
      o_RAM_RD_n = 1'b0;
    end else if (cpu_issue_s) begin
      o_RAM_ADDR    = cpu_addr_s;
      o_RAM_RD_n    = cpu_rd_n_s;
      o_RAM_WR_HI_n = cpu_wr_hi_n_s;
      o_RAM_WR_LO_n = cpu_wr_lo_n_s;
    end else begin
      o_RAM_ADDR = i_VID_ADDR;
    end
  end

  // Video pipe: slot edge issues the read, next edge latches the colour.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      vid_pend_q  <= 1'b0;
      vid_blank_q <= 1'b0;
      rgb_q       <= {RGB_W{1'b0}};
      rgb_valid_q <= 1'b0;
    end else begin
      vid_pend_q  <= i_PXCEN;
      rgb_valid_q <= vid_pend_q;
      if (i_PXCEN) begin
        vid_blank_q <= i_VID_BLANK;
      end else begin
        vid_blank_q <= vid_blank_q;
      end
      if (vid_pend_q) begin
        rgb_q <= vid_blank_q ? {RGB_W{1'b0}} : i_RAM_DOUT[RGB_W-1:0];
      end else begin
        rgb_q <= rgb_q;
      end
    end
  end

  assign o_RGB       = rgb_q;
  assign o_RGB_VALID = rgb_valid_q;

endmodule

// File: tb/tb_colorram_arbiter.sv
// Directed bench for colorram_arbiter with a two-chip RAM model.
module tb_colorram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, pxcen, vid_blank, cs_n, r_nw, uds_n, lds_n, ram_init;
  logic [10:0] vid_addr, cpu_addr, ram_addr;
  logic [15:0] cpu_din, cpu_dout, ram_din, ram_dout;
  logic        dtack_n, wr_hi_n, wr_lo_n, rd_n, rgb_valid;
  logic [14:0] rgb;
  logic [7:0]  mem_hi [2048];
  logic [7:0]  mem_lo [2048];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_hi_cnt, wr_lo_cnt;

  always #5 clk = ~clk;

  colorram_arbiter dut (
    .i_MCLK        (clk),
    .i_RST_n       (rst_n),
    .i_PXCEN       (pxcen),
    .i_VID_ADDR    (vid_addr),
    .i_VID_BLANK   (vid_blank),
    .i_CPU_CS_n    (cs_n),
    .i_CPU_R_nW    (r_nw),
    .i_CPU_UDS_n   (uds_n),
    .i_CPU_LDS_n   (lds_n),
    .i_CPU_ADDR    (cpu_addr),
    .i_CPU_DIN     (cpu_din),
    .o_CPU_DOUT    (cpu_dout),
    .o_CPU_DTACK_n (dtack_n),
    .o_RAM_ADDR    (ram_addr),
    .o_RAM_DIN     (ram_din),
    .o_RAM_WR_HI_n (wr_hi_n),
    .o_RAM_WR_LO_n (wr_lo_n),
    .o_RAM_RD_n    (rd_n),
    .i_RAM_DOUT    (ram_dout),
    .o_RGB         (rgb),
    .o_RGB_VALID   (rgb_valid)
  );

  // Two 2k x 8 chips with synchronous read and per-chip write strobes.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) begin
        mem_hi[i] <= 8'h0F;
        mem_lo[i] <= 8'h0F;
      end
      mem_hi[11'h123] <= 8'h7C; mem_lo[11'h123] <= 8'h1F;
      mem_hi[11'h045] <= 8'h12; mem_lo[11'h045] <= 8'h34;
      mem_hi[11'h7FF] <= 8'h5A; mem_lo[11'h7FF] <= 8'h3C;
      ram_dout <= 16'h0000;
    end else begin
      if (!rd_n) ram_dout <= {mem_hi[ram_addr], mem_lo[ram_addr]};
      if (!wr_hi_n) mem_hi[ram_addr] <= ram_din[15:8];
      if (!wr_lo_n) mem_lo[ram_addr] <= ram_din[7:0];
    end
  end

  // Count write strobes seen by the RAM at each clock edge.
  always @(posedge clk) begin
    if (ram_init) begin
      wr_hi_cnt <= 0;
      wr_lo_cnt <= 0;
    end else begin
      if (!wr_hi_n) wr_hi_cnt <= wr_hi_cnt + 1;
      if (!wr_lo_n) wr_lo_cnt <= wr_lo_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Three-edge access with no stalls: DTACK low after the third edge.
  task automatic cpu_access(input string tag, input logic rnw, input logic [10:0] a,
                            input logic [15:0] d, input logic u_n, input logic l_n);
    r_nw = rnw; cpu_addr = a; cpu_din = d; uds_n = u_n; lds_n = l_n; cs_n = 1'b0;
    step(1);
    check_val({tag, "_dtk1"}, 32'(dtack_n), 32'd1);
    step(1);
    check_val({tag, "_dtk2"}, 32'(dtack_n), 32'd1);
    step(1);
    check_val({tag, "_dtk3"}, 32'(dtack_n), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ram_init = 1'b1; pxcen = 1'b0; vid_blank = 1'b0;
    cs_n = 1'b0; r_nw = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    vid_addr = 11'h123; cpu_addr = 11'h045; cpu_din = 16'h5555;

    // Reset with CS_n asserted and PXCEN toggling
    for (int c = 0; c < 4; c++) begin
      pxcen = c[0];
      #1;
      check_val("rst_rd_n", 32'(rd_n), 32'd1);
      check_val("rst_wr_hi_n", 32'(wr_hi_n), 32'd1);
      check_val("rst_wr_lo_n", 32'(wr_lo_n), 32'd1);
      step(1);
      check_val("rst_dtack_n", 32'(dtack_n), 32'd1);
      check_val("rst_rgb", 32'(rgb), 32'd0);
      check_val("rst_valid", 32'(rgb_valid), 32'd0);
      check_val("rst_dout", 32'(cpu_dout), 32'd0);
    end
    cs_n = 1'b1; pxcen = 1'b0; ram_init = 1'b0;
    rst_n = 1'b1;
    step(1);

    // Video slot every 4th cycle, blanked once
    for (int c = 0; c < 12; c++) begin
      pxcen = ((c % 4) == 0);
      vid_blank = (c == 8);
      #1;
      check_val("vid_rd_n", 32'(rd_n), 32'(!pxcen));
      step(1);
      check_val("vid_valid", 32'(rgb_valid), 32'(((c % 4) == 1)));
      if ((c % 4) == 1) check_val("vid_rgb", 32'(rgb), (c == 9) ? 32'h0 : 32'h7C1F);
    end

    // Back-to-back video slots
    pxcen = 1'b1;
    step(1);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) pxcen = 1'b0;
      step(1);
      check_val("b2b_valid", 32'(rgb_valid), 32'd1);
      check_val("b2b_rgb", 32'(rgb), 32'h7C1F);
    end
    step(1);
    check_val("b2b_valid_end", 32'(rgb_valid), 32'd0);

    // CPU tests run during blanking so both builds behave alike
    vid_blank = 1'b1;

    // Upper-byte write of 0xABCD to 0x045
    r_nw = 1'b0; cpu_addr = 11'h045; cpu_din = 16'hABCD; uds_n = 1'b0; lds_n = 1'b1; cs_n = 1'b0;
    step(1);
    check_val("wr_addr", 32'(ram_addr), 32'h045);
    check_val("wr_din", 32'(ram_din), 32'hABCD);
    check_val("wr_hi_low", 32'(wr_hi_n), 32'd0);
    check_val("wr_lo_high", 32'(wr_lo_n), 32'd1);
    check_val("wr_dtk1", 32'(dtack_n), 32'd1);
    step(1);
    check_val("wr_hi_off", 32'(wr_hi_n), 32'd1);
    check_val("wr_dtk2", 32'(dtack_n), 32'd1);
    step(1);
    check_val("wr_dtk3", 32'(dtack_n), 32'd0);
    step(2);
    check_val("wr_dtk_hold", 32'(dtack_n), 32'd0);
    cs_n = 1'b1;
    step(1);
    check_val("wr_dtk_release", 32'(dtack_n), 32'd1);
    check_val("wr_hi_cnt", 32'(wr_hi_cnt), 32'd1);
    check_val("wr_lo_cnt", 32'(wr_lo_cnt), 32'd0);

    // Read back 0x045 with a video slot during CAPTURE
    r_nw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; cs_n = 1'b0;
    step(1);
    check_val("rd_rd_n", 32'(rd_n), 32'd0);
    step(1);
    check_val("rd_dtk2", 32'(dtack_n), 32'd1);
    pxcen = 1'b1;
    step(1);
    pxcen = 1'b0;
    check_val("rd_dtk3", 32'(dtack_n), 32'd0);
    check_val("rd_dout", 32'(cpu_dout), 32'hAB34);
    cs_n = 1'b1;
    step(1);

    // Read of 0x7FF stalled by 5 video slots
    r_nw = 1'b1; cpu_addr = 11'h7FF; cs_n = 1'b0;
    step(1);
    pxcen = 1'b1;
    #1;
    check_val("stall_addr", 32'(ram_addr), 32'h123);
    for (int e = 2; e <= 8; e++) begin
      if (e == 7) pxcen = 1'b0;
      step(1);
      check_val("stall_dtack", 32'(dtack_n), 32'((e < 8)));
    end
    check_val("stall_dout", 32'(cpu_dout), 32'h5A3C);
    cs_n = 1'b1;
    step(1);

    // Write with both strobes inactive still acknowledges
    cpu_access("noop", 1'b0, 11'h045, 16'hFFFF, 1'b1, 1'b1);
    cs_n = 1'b1;
    step(1);
    check_val("noop_hi_cnt", 32'(wr_hi_cnt), 32'd1);
    check_val("noop_lo_cnt", 32'(wr_lo_cnt), 32'd0);

    // Reset while a write is parked in ISSUE
    r_nw = 1'b0; cpu_addr = 11'h100; cpu_din = 16'hFFFF; uds_n = 1'b0; lds_n = 1'b0;
    pxcen = 1'b1; cs_n = 1'b0;
    step(1);
    rst_n = 1'b0;
    #1;
    check_val("rsti_wr_hi_n", 32'(wr_hi_n), 32'd1);
    check_val("rsti_rd_n", 32'(rd_n), 32'd1);
    pxcen = 1'b0;
    step(2);
    check_val("rsti_dtack_n", 32'(dtack_n), 32'd1);
    cs_n = 1'b1;
    rst_n = 1'b1;
    step(1);
    check_val("rsti_hi_cnt", 32'(wr_hi_cnt), 32'd1);
    check_val("rsti_lo_cnt", 32'(wr_lo_cnt), 32'd0);
    cpu_access("rsti_rd", 1'b1, 11'h100, 16'h0000, 1'b0, 1'b0);
    check_val("rsti_rd_dout", 32'(cpu_dout), 32'h0F0F);
    cs_n = 1'b1;
    step(1);

`ifdef COLORRAM_CONTENTION_EN
    // Active display holds the CPU off until blanking
    vid_blank = 1'b0; r_nw = 1'b1; cpu_addr = 11'h045; cs_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check_val("cont_dtack_hold", 32'(dtack_n), 32'd1);
    end
    vid_blank = 1'b1;
    step(1);
    check_val("cont_dtack_a", 32'(dtack_n), 32'd1);
    step(1);
    check_val("cont_dtack_b", 32'(dtack_n), 32'd0);
    check_val("cont_dout", 32'(cpu_dout), 32'hAB34);
    cs_n = 1'b1;
    step(1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
